// File: rtl/multi_pattern_seq_detector_pkg.sv
// multi_pattern_seq_detector_pkg: shared defaults and mode encoding for the pattern detector
package multi_pattern_seq_detector_pkg;
  localparam int SEQ_LEN_DEF = 4;
  localparam int NUM_PAT_DEF = 3;
  localparam logic [SEQ_LEN_DEF*NUM_PAT_DEF-1:0] PATTERNS_DEF = {4'b1110, 4'b1001, 4'b0111};
  typedef enum logic {MODE_FRAMED = 1'b0, MODE_SLIDING = 1'b1} mode_e;
endpackage

// File: rtl/multi_pattern_seq_detector_slot.sv
// seq_match_slot: one pattern slot holding its pattern and frame-alive flag, producing per-mode hits
module seq_match_slot
  import multi_pattern_seq_detector_pkg::*;
#(
  parameter int SEQ_LEN = SEQ_LEN_DEF,
  parameter int CW = $clog2(SEQ_LEN),
  parameter logic [SEQ_LEN-1:0] RST_PAT = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               wr_i,
  input  logic [SEQ_LEN-1:0] pat_i,
  input  logic               step_i,
  input  logic               last_i,
  input  logic [CW-1:0]      bit_cnt_i,
  input  logic [SEQ_LEN-1:0] win_i,
  input  logic               in_i,
  output logic               frame_hit_o,
  output logic               slide_hit_o
);
  logic [SEQ_LEN-1:0] pat_q, pat_d, sh;
  logic               alive_q, alive_d;
  always_comb begin
    sh = pat_q << bit_cnt_i;
    pat_d = wr_i ? pat_i : pat_q;
    alive_d = clr_i ? 1'b1 : step_i ? (last_i | (alive_q & (in_i == sh[SEQ_LEN-1]))) : alive_q;
    frame_hit_o = alive_q & (in_i == pat_q[0]);
    slide_hit_o = win_i == pat_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q <= RST_PAT;
      alive_q <= 1'b1;
    end else begin
      pat_q <= pat_d;
      alive_q <= alive_d;
    end
  end
endmodule

// File: rtl/multi_pattern_seq_detector.sv
// multi_pattern_seq_detector: programmable framed/sliding Mealy detector for several serial patterns
module multi_pattern_seq_detector
  import multi_pattern_seq_detector_pkg::*;
#(
  parameter int SEQ_LEN = SEQ_LEN_DEF,
  parameter int NUM_PAT = NUM_PAT_DEF,
  parameter int IDX_W = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1,
  parameter logic [SEQ_LEN*NUM_PAT-1:0] PATTERNS = PATTERNS_DEF,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_i,
  input  logic               in_valid_i,
  input  logic               cfg_we_i,
  input  logic [IDX_W-1:0]   cfg_idx_i,
  input  logic [SEQ_LEN-1:0] cfg_pattern_i,
  input  logic [NUM_PAT-1:0] cfg_en_mask_i,
  input  logic               cfg_mode_i,
  output logic               dec_o,
  output logic [IDX_W-1:0]   dec_id_o,
  output logic               frame_done_o,
  output logic [CNT_W-1:0]   match_count_o
);
  localparam int CW = $clog2(SEQ_LEN);
  localparam logic [CW-1:0] LAST = CW'(SEQ_LEN - 1);
  mode_e               mode_q, mode_d;
  logic [NUM_PAT-1:0]  en_q, en_d, fh, shit, hits;
  logic [CW-1:0]       bit_cnt_q, bit_cnt_d, fill_q, fill_d;
  logic [SEQ_LEN-2:0]  hist_q, hist_d;
  logic [SEQ_LEN-1:0]  win;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                act, last, full;
  assign win = {hist_q, in_i};
  assign act = in_valid_i & ~cfg_we_i & ~rst;
  assign last = bit_cnt_q == LAST;
  assign full = fill_q == LAST;
  for (genvar i = 0; i < NUM_PAT; i++) begin : g_slot
    seq_match_slot #(.SEQ_LEN(SEQ_LEN), .CW(CW), .RST_PAT(PATTERNS[i*SEQ_LEN +: SEQ_LEN])) u_slot (
      .clk(clk), .rst(rst), .clr_i(cfg_we_i), .wr_i(cfg_we_i && cfg_idx_i == IDX_W'(i)),
      .pat_i(cfg_pattern_i), .step_i(act), .last_i(last), .bit_cnt_i(bit_cnt_q), .win_i(win),
      .in_i(in_i), .frame_hit_o(fh[i]), .slide_hit_o(shit[i]));
  end
  always_comb begin
    hits = en_q & {NUM_PAT{act}} & (mode_q == MODE_SLIDING ? (full ? shit : '0) : (last ? fh : '0));
    dec_o = |hits;
    dec_id_o = '0;
    for (int k = NUM_PAT - 1; k >= 0; k--) if (hits[k]) dec_id_o = IDX_W'(k);
    frame_done_o = act & last & (mode_q == MODE_FRAMED);
    mode_d = cfg_we_i ? mode_e'(cfg_mode_i) : mode_q;
    en_d = cfg_we_i ? cfg_en_mask_i : en_q;
    bit_cnt_d = cfg_we_i ? '0 : act ? (last ? '0 : bit_cnt_q + CW'(1)) : bit_cnt_q;
    fill_d = cfg_we_i ? '0 : (act && !full) ? fill_q + CW'(1) : fill_q;
    hist_d = cfg_we_i ? '0 : act ? win[SEQ_LEN-2:0] : hist_q;
    cnt_d = (dec_o && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    match_count_o = cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_FRAMED;
      en_q <= '1;
      bit_cnt_q <= '0;
      fill_q <= '0;
      hist_q <= '0;
      cnt_q <= '0;
    end else begin
      mode_q <= mode_d;
      en_q <= en_d;
      bit_cnt_q <= bit_cnt_d;
      fill_q <= fill_d;
      hist_q <= hist_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_multi_pattern_seq_detector.sv
// tb_multi_pattern_seq_detector: directed self-checking bench for the multi-pattern detector
module tb_multi_pattern_seq_detector;
  logic clk = 1'b0, rst = 1'b1, in_i = 1'b0, in_valid_i = 1'b0, cfg_we_i = 1'b0, cfg_mode_i = 1'b0;
  logic [1:0] cfg_idx_i = '0;
  logic [3:0] cfg_pattern_i = '0;
  logic [2:0] cfg_en_mask_i = '0;
  logic dec, fd, dec2, fd2;
  logic [1:0] id, id2, mc2;
  logic [15:0] mc;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  multi_pattern_seq_detector dut (
    .clk(clk), .rst(rst), .in_i(in_i), .in_valid_i(in_valid_i), .cfg_we_i(cfg_we_i),
    .cfg_idx_i(cfg_idx_i), .cfg_pattern_i(cfg_pattern_i), .cfg_en_mask_i(cfg_en_mask_i),
    .cfg_mode_i(cfg_mode_i), .dec_o(dec), .dec_id_o(id), .frame_done_o(fd), .match_count_o(mc));
  multi_pattern_seq_detector #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_i(in_i), .in_valid_i(in_valid_i), .cfg_we_i(cfg_we_i),
    .cfg_idx_i(cfg_idx_i), .cfg_pattern_i(cfg_pattern_i), .cfg_en_mask_i(cfg_en_mask_i),
    .cfg_mode_i(cfg_mode_i), .dec_o(dec2), .dec_id_o(id2), .frame_done_o(fd2), .match_count_o(mc2));

  task drive(input logic b, input logic v);
    @(negedge clk);
    rst = 1'b0; cfg_we_i = 1'b0; in_i = b; in_valid_i = v;
    #1;
  endtask

  task cfg(input logic [1:0] idx, input logic [3:0] p, input logic [2:0] m, input logic md, input logic v);
    @(negedge clk);
    cfg_we_i = 1'b1; cfg_idx_i = idx; cfg_pattern_i = p; cfg_en_mask_i = m; cfg_mode_i = md;
    in_valid_i = v; in_i = 1'b1;
    #1;
  endtask

  task do_reset;
    @(negedge clk);
    rst = 1'b1; in_valid_i = 1'b0; cfg_we_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task test_reset;
    @(negedge clk);
    rst = 1'b1; in_valid_i = 1'b1; in_i = 1'b1; cfg_we_i = 1'b0;
    #1;
    checks++;
    if (dec !== 1'b0 || id !== 2'd0 || fd !== 1'b0) begin
      errors++; $display("FAIL reset_gate: dec=%b id=%0d fd=%b expected 0 0 0", dec, id, fd);
    end
    @(negedge clk);
    checks++;
    if (mc !== 16'd0 || mc2 !== 2'd0) begin
      errors++; $display("FAIL reset_count: mc=%0d mc2=%0d expected 0 0", mc, mc2);
    end
    rst = 1'b0; in_valid_i = 1'b0;
  endtask

  task test_default_framed;
    logic [15:0] s;
    logic ed, ef;
    logic [1:0] ei;
    s = 16'b0111_1001_1110_0000;
    do_reset;
    for (int k = 0; k < 16; k++) begin
      drive(s[15-k], 1'b1);
      ed = (k == 3 || k == 7 || k == 11);
      ei = (k == 7) ? 2'd1 : (k == 11) ? 2'd2 : 2'd0;
      ef = (k % 4 == 3);
      checks++;
      if (dec !== ed || id !== ei || fd !== ef) begin
        errors++; $display("FAIL framed_bit%0d: dec=%b id=%0d fd=%b expected %b %0d %b", k + 1, dec, id, fd, ed, ei, ef);
      end
    end
    drive(1'b0, 1'b0);
    checks++;
    if (mc !== 16'd3) begin
      errors++; $display("FAIL framed_count: mc=%0d expected 3", mc);
    end
  endtask

  task test_misaligned;
    logic [8:0] s;
    s = 9'b1_0111_1001;
    do_reset;
    for (int k = 0; k < 9; k++) begin
      drive(s[8-k], 1'b1);
      checks++;
      if (dec !== 1'b0 || fd !== (k == 3 || k == 7)) begin
        errors++; $display("FAIL misalign_bit%0d: dec=%b fd=%b expected 0 %b", k + 1, dec, fd, (k == 3 || k == 7));
      end
    end
    drive(1'b0, 1'b0);
    checks++;
    if (mc !== 16'd0) begin
      errors++; $display("FAIL misalign_count: mc=%0d expected 0", mc);
    end
  endtask

  task test_sliding;
    do_reset;
    cfg(2'd0, 4'b1111, 3'b111, 1'b1, 1'b0);
    checks++;
    if (dec !== 1'b0) begin
      errors++; $display("FAIL slide_cfg: dec=%b expected 0", dec);
    end
    for (int k = 0; k < 11; k++) begin
      drive(1'b1, 1'b1);
      checks++;
      if (dec !== (k >= 3) || id !== 2'd0 || fd !== 1'b0) begin
        errors++; $display("FAIL slide_bit%0d: dec=%b id=%0d fd=%b expected %b 0 0", k + 1, dec, id, fd, (k >= 3));
      end
    end
    drive(1'b0, 1'b0);
    checks++;
    if (mc !== 16'd8) begin
      errors++; $display("FAIL slide_count: mc=%0d expected 8", mc);
    end
  endtask

  task test_cfg_midframe;
    do_reset;
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    cfg(2'd1, 4'b0000, 3'b111, 1'b0, 1'b1);
    checks++;
    if (dec !== 1'b0 || fd !== 1'b0) begin
      errors++; $display("FAIL cfg_drop: dec=%b fd=%b expected 0 0", dec, fd);
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1);
      checks++;
      if (dec !== (k == 3) || id !== ((k == 3) ? 2'd1 : 2'd0) || fd !== (k == 3)) begin
        errors++; $display("FAIL cfg_frame_bit%0d: dec=%b id=%0d fd=%b expected %b %0d %b", k + 1, dec, id, fd, (k == 3), (k == 3) ? 1 : 0, (k == 3));
      end
    end
  endtask

  task test_en_mask;
    logic [3:0] a, b;
    a = 4'b0111; b = 4'b1001;
    do_reset;
    cfg(2'd3, 4'b0000, 3'b010, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive(a[3-k], 1'b1);
      checks++;
      if (dec !== 1'b0 || fd !== (k == 3)) begin
        errors++; $display("FAIL mask_off_bit%0d: dec=%b fd=%b expected 0 %b", k + 1, dec, fd, (k == 3));
      end
    end
    for (int k = 0; k < 4; k++) begin
      drive(b[3-k], 1'b1);
      checks++;
      if (dec !== (k == 3) || id !== ((k == 3) ? 2'd1 : 2'd0)) begin
        errors++; $display("FAIL mask_on_bit%0d: dec=%b id=%0d expected %b %0d", k + 1, dec, id, (k == 3), (k == 3) ? 1 : 0);
      end
    end
    cfg(2'd3, 4'b0000, 3'b000, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive(b[3-k], 1'b1);
      checks++;
      if (dec !== 1'b0 || fd !== (k == 3)) begin
        errors++; $display("FAIL all_off_bit%0d: dec=%b fd=%b expected 0 %b", k + 1, dec, fd, (k == 3));
      end
    end
  endtask

  task test_saturate_and_rst;
    logic [3:0] a, b;
    a = 4'b0111; b = 4'b1001;
    do_reset;
    for (int f = 0; f < 5; f++) for (int k = 0; k < 4; k++) drive(a[3-k], 1'b1);
    drive(1'b0, 1'b0);
    checks++;
    if (mc !== 16'd5 || mc2 !== 2'd3) begin
      errors++; $display("FAIL saturate: mc=%0d mc2=%0d expected 5 3", mc, mc2);
    end
    cfg(2'd0, 4'b0000, 3'b001, 1'b1, 1'b0);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    @(negedge clk);
    rst = 1'b1; in_valid_i = 1'b1; in_i = 1'b0; cfg_we_i = 1'b0;
    #1;
    checks++;
    if (dec !== 1'b0 || id !== 2'd0 || fd !== 1'b0) begin
      errors++; $display("FAIL midrst_gate: dec=%b id=%0d fd=%b expected 0 0 0", dec, id, fd);
    end
    @(negedge clk);
    checks++;
    if (mc !== 16'd0 || mc2 !== 2'd0) begin
      errors++; $display("FAIL midrst_count: mc=%0d mc2=%0d expected 0 0", mc, mc2);
    end
    for (int k = 0; k < 4; k++) begin
      drive(a[3-k], 1'b1);
      checks++;
      if (dec !== (k == 3) || id !== 2'd0 || fd !== (k == 3)) begin
        errors++; $display("FAIL midrst_f0_bit%0d: dec=%b id=%0d fd=%b expected %b 0 %b", k + 1, dec, id, fd, (k == 3), (k == 3));
      end
    end
    for (int k = 0; k < 4; k++) begin
      drive(b[3-k], 1'b1);
      checks++;
      if (dec !== (k == 3) || id !== ((k == 3) ? 2'd1 : 2'd0)) begin
        errors++; $display("FAIL midrst_f1_bit%0d: dec=%b id=%0d expected %b %0d", k + 1, dec, id, (k == 3), (k == 3) ? 1 : 0);
      end
    end
  endtask

  initial begin
    test_reset;
    test_default_framed;
    test_misaligned;
    test_sliding;
    test_cfg_midframe;
    test_en_mask;
    test_saturate_and_rst;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
